// File: rtl/bsram_dump_reader.sv
// Streams BSRAM words out as bytes (high byte first) with an optional trailing checksum byte.
// First byte 2+READ_LAT cycles after start; tx_valid depends on state only and holds until tx_ready.
module bsram_dump_reader #(
    parameter int ADDR_W      = 11,
    parameter int DATA_W      = 16,
    parameter int READ_LAT    = 1,
    parameter int CHECKSUM_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   word_count,
    input  logic              abort,
    output logic              mem_ce,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_dout,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_SEND_HI,
        S_SEND_LO,
        S_SEND_CK,
        S_DONE
    } state_t;

    // After the last word (or an empty dump) either the checksum is sent or we finish directly.
    localparam state_t           S_END    = (CHECKSUM_EN != 0) ? S_SEND_CK : S_DONE;
    localparam logic [1:0]       LAT_LAST = 2'(READ_LAT - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W:0]     count_q;
    logic [7:0]          sum_q;
    logic [DATA_W-1:0]   word_q;
    logic [1:0]          lat_q;
    logic                xfer;

    assign xfer     = tx_valid && tx_ready;
    assign mem_addr = addr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start) state_nxt = (word_count == '0) ? S_END : S_REQ;
            S_REQ:     state_nxt = S_WAIT;
            S_WAIT:    if (lat_q == LAT_LAST) state_nxt = S_SEND_HI;
            S_SEND_HI: if (xfer) state_nxt = S_SEND_LO;
            S_SEND_LO: if (xfer) state_nxt = (count_q == CNT_ONE) ? S_END : S_REQ;
            S_SEND_CK: if (xfer) state_nxt = S_DONE;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
        if (abort) begin
            state_nxt = S_IDLE;
        end
    end

    always_comb begin
        mem_ce   = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        busy     = 1'b1;
        done     = 1'b0;
        case (state)
            S_IDLE:    busy = 1'b0;
            S_REQ:     mem_ce = 1'b1;
            S_WAIT:    busy = 1'b1;
            S_SEND_HI: begin
                tx_valid = 1'b1;
                tx_data  = word_q[15:8];
            end
            S_SEND_LO: begin
                tx_valid = 1'b1;
                tx_data  = word_q[7:0];
            end
            S_SEND_CK: begin
                tx_valid = 1'b1;
                tx_data  = 8'h00 - sum_q;
            end
            S_DONE: begin
                busy = 1'b0;
                done = 1'b1;
            end
            default:   busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            count_q <= '0;
            sum_q   <= '0;
            word_q  <= '0;
            lat_q   <= '0;
        end else begin
            if (state == S_IDLE && start && !abort) begin
                addr_q  <= start_addr;
                count_q <= word_count;
                sum_q   <= '0;
            end
            lat_q <= (state == S_WAIT) ? lat_q + 2'd1 : 2'd0;
            // Read data is only trusted on the final WAIT edge.
            if (state == S_WAIT && lat_q == LAT_LAST) begin
                word_q <= mem_dout;
            end
            if (xfer && (state == S_SEND_HI || state == S_SEND_LO)) begin
                sum_q <= sum_q + tx_data;
            end
            if (xfer && state == S_SEND_LO) begin
                count_q <= count_q - CNT_ONE;
                addr_q  <= addr_q + ADDR_ONE;
            end
        end
    end

endmodule

// File: tb/tb_bsram_dump_reader.sv
// Scoreboard bench: a byte-stream model pushes expected bytes/addresses; monitors pop and compare.
module tb_bsram_dump_reader;

    localparam int AW = 11;
    localparam int RL = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [AW:0]   word_count;
    logic          abort;
    logic          mem_ce;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_dout;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          busy;
    logic          done;

    bsram_dump_reader #(
        .ADDR_W(AW), .DATA_W(16), .READ_LAT(RL), .CHECKSUM_EN(1)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
        .word_count(word_count), .abort(abort), .mem_ce(mem_ce), .mem_addr(mem_addr),
        .mem_dout(mem_dout), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory with RL-cycle read pipeline; garbage on the bus when not reading.
    logic [15:0] mem [0:(1<<AW)-1];
    logic [15:0] pipe [0:RL-1];
    always @(posedge clk) begin
        pipe[0] <= mem_ce ? mem[mem_addr] : 16'($urandom);
        for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_dout = pipe[RL-1];

    // Scoreboard state
    logic [7:0]    exp_q[$];
    logic [AW-1:0] addr_q[$];
    bit            done_pending = 0;
    bit            lat_pending = 0;
    int            start_cyc = 0;
    int            rx_count = 0;
    bit            hold_vld = 0;
    logic [7:0]    hold_dat;

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_ce) begin
                if (addr_q.size() == 0) check("mem_ce_unexpected", 1, 0);
                else check("mem_addr", mem_addr, addr_q.pop_front());
            end
            if (lat_pending && tx_valid) begin
                check("first_byte_latency", cyc - start_cyc, 2 + RL);
                lat_pending = 0;
            end
            if (hold_vld) begin
                check("hold_valid", tx_valid, 1);
                check("hold_data", tx_data, hold_dat);
            end
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) check("byte_unexpected", tx_data, 'h100);
                else check("tx_byte", tx_data, exp_q.pop_front());
                rx_count++;
            end
            hold_vld = tx_valid && !tx_ready && !abort;
            hold_dat = tx_data;
            if (done) begin
                check("done_expected", done_pending, 1);
                check("bytes_left_at_done", exp_q.size(), 0);
                check("busy_at_done", busy, 0);
                done_pending = 0;
            end
        end else begin
            hold_vld = 0;
        end
    end

    // tx_ready driver: 0 = always ready, 1 = random, 2 = five stall cycles per byte
    int mode = 0;
    initial begin
        int  stall = 0;
        bit  prev_xfer = 0;
        tx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (prev_xfer) stall = 0;
            case (mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    tx_ready = tx_valid && (stall >= 5);
                    if (tx_valid) stall++;
                end
            endcase
            prev_xfer = tx_valid && tx_ready;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: the dump is the byte sequence of consecutive (wrapping) words plus a zero-sum byte.
    task automatic start_dump(input logic [AW-1:0] a, input int n);
        logic [7:0]    sum = 8'h00;
        logic [AW-1:0] ad;
        for (int i = 0; i < n; i++) begin
            ad = a + AW'(i);
            addr_q.push_back(ad);
            exp_q.push_back(mem[ad][15:8]);
            exp_q.push_back(mem[ad][7:0]);
            sum = sum + mem[ad][15:8] + mem[ad][7:0];
        end
        exp_q.push_back(8'h00 - sum);
        done_pending = 1;
        lat_pending = (n > 0);
        start = 1'b1;
        start_addr = a;
        word_count = (AW + 1)'(n);
        start_cyc = cyc;
        step();
        start = 1'b0;
        start_addr = $urandom;
        word_count = $urandom;
    endtask

    task automatic stray_start();
        start = 1'b1;
        start_addr = $urandom;
        word_count = $urandom_range(1, 50);
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (done_pending && k < budget) begin
            step();
            k++;
        end
        if (done_pending) begin
            check("done_timeout", 0, 1);
            done_pending = 0;
        end
        step();
    endtask

    task automatic flush();
        exp_q.delete();
        addr_q.delete();
        done_pending = 0;
        lat_pending = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_ce"}, mem_ce, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_tx_data"}, tx_data, 0);
        check({tag, "_tx_valid"}, tx_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    initial begin
        int base;
        int k;
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        start_addr = '0;
        word_count = '0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 16'($urandom);
        mem[0] = 16'h00A1;
        mem[1] = 16'h0078;
        mem[2] = 16'h0066;
        repeat (3) step();
        check_all_zero("reset");
        rst = 1'b0;
        step();

        // Basic stream, then the same under heavy backpressure.
        mode = 0;
        start_dump(0, 3);
        wait_done(200);
        mode = 2;
        start_dump(0, 3);
        wait_done(400);

        // Address wrap and empty dump.
        mode = 1;
        start_dump(11'h7FF, 2);
        wait_done(400);
        start_dump(11'h123, 0);
        wait_done(100);

        // Abort just after the third byte has transferred.
        mode = 0;
        base = rx_count;
        start_dump(0, 3);
        k = 0;
        while (rx_count - base < 3 && k < 100) begin
            step();
            k++;
        end
        check("abort_reached_third_byte", rx_count - base >= 3, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_tx_valid", tx_valid, 0);
        check("abort_mem_ce", mem_ce, 0);
        flush();
        repeat (5) step();
        start_dump(11'h005, 4);
        wait_done(400);

        // Start pulses while busy must not disturb the dump in progress.
        mode = 1;
        start_dump(11'h010, 4);
        repeat (2) step();
        stray_start();
        repeat (7) step();
        stray_start();
        wait_done(400);

        // Reset during WAIT, with a stray start just before.
        start_dump(11'h020, 3);
        stray_start();
        k = 0;
        while (addr_q.size() == 3 && k < 50) begin
            step();
            k++;
        end
        rst = 1'b1;
        step();
        check_all_zero("midrst");
        rst = 1'b0;
        flush();
        step();

        // Randomized dumps, including near the top of memory and one full-memory dump.
        for (int t = 0; t < 14; t++) begin
            mode = $urandom_range(0, 2);
            if (t % 3 == 0) start_dump(AW'(11'h7FC + $urandom_range(0, 3)), $urandom_range(0, 6));
            else start_dump(AW'($urandom), $urandom_range(0, 8));
            wait_done(1000);
        end
        mode = 0;
        start_dump(11'h3FF, 1 << AW);
        wait_done(20000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
